// File: rtl/expander_pkg.sv
// Shared types and default sizing for the serial GPIO expander blocks.
package expander_pkg;
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} exp_state_t;

  localparam int EXP_WIDTH       = 16;
  localparam int EXP_SCALER      = 100;
  localparam int EXP_POLL_CYCLES = 1000;
endpackage

// File: rtl/exp_tick_gen.sv
// Serial tick divider: one-cycle tick every SCALER+1 clocks, restartable by clr_i.
module exp_tick_gen #(
  parameter int SCALER = expander_pkg::EXP_SCALER
) (
  input  logic i_clk,
  input  logic nreset_i,
  input  logic clr_i,
  output logic tick_o
);
  localparam int CW = (SCALER > 0) ? $clog2(SCALER + 1) : 1;
  localparam logic [CW-1:0] TERM = CW'(SCALER);

  logic [CW-1:0] cnt;

  assign tick_o = (cnt == TERM);

  always_ff @(posedge i_clk or negedge nreset_i) begin
    if (!nreset_i)               cnt <= '0;
    else if (clr_i || tick_o)    cnt <= '0;
    else                         cnt <= cnt + CW'(1);
  end
endmodule

// File: rtl/expander_gpio_sched.sv
// Shares the expander shift chain between host writes and a periodic input poll;
// every transaction shifts the output shadow out while capturing the inputs.
module expander_gpio_sched
  import expander_pkg::*;
#(
  parameter int               WIDTH       = EXP_WIDTH,
  parameter int               SCALER      = EXP_SCALER,
  parameter int               POLL_CYCLES = EXP_POLL_CYCLES,
  parameter logic [WIDTH-1:0] RESET_OUT   = '0
) (
  input  logic             i_clk,
  input  logic             nreset_i,
  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             rd_valid_o,
  output logic             busy_o,
  output logic             exp_cs_n_o,
  output logic             exp_sclk_o,
  output logic             exp_sdo_o,
  input  logic             exp_sdi_i
);
  localparam int BW = $clog2(2 * WIDTH + 1);
  localparam int IW = $clog2(POLL_CYCLES);
  localparam logic [BW-1:0] LAST_TICK = BW'(2 * WIDTH);
  localparam logic [IW-1:0] IDLE_TERM = IW'(POLL_CYCLES - 1);
  localparam logic [IW-1:0] POLL_SET  = IW'(POLL_CYCLES - 2);

  exp_state_t       state;
  logic [WIDTH-1:0] shadow, tx_sr, cap;
  logic [BW-1:0]    bit_cnt, bit_num;
  logic [IW-1:0]    idle_cnt;
  logic             poll_pend, tick, wr_acc;
  logic [WIDTH-1:0] start_word;

  assign wr_ready_o = (state == IDLE);
  assign busy_o     = (state == SHIFT);
  assign wr_acc     = wr_valid_i & wr_ready_o;
  assign start_word = wr_acc ? wr_data_i : shadow;
  assign bit_num    = bit_cnt + BW'(1);

  // Divider is held cleared while idle so the first tick lands P cycles after cs_n falls.
  exp_tick_gen #(.SCALER(SCALER)) u_tick (
    .i_clk    (i_clk),
    .nreset_i (nreset_i),
    .clr_i    (state == IDLE),
    .tick_o   (tick)
  );

  always_ff @(posedge i_clk or negedge nreset_i) begin
    if (!nreset_i) begin
      state      <= IDLE;
      shadow     <= RESET_OUT;
      tx_sr      <= '0;
      cap        <= '0;
      bit_cnt    <= '0;
      idle_cnt   <= '0;
      poll_pend  <= 1'b1;
      rd_data_o  <= '0;
      rd_valid_o <= 1'b0;
      exp_cs_n_o <= 1'b1;
      exp_sclk_o <= 1'b0;
      exp_sdo_o  <= 1'b0;
    end else begin
      rd_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_acc || poll_pend) begin
            if (wr_acc) shadow <= wr_data_i;
            state      <= SHIFT;
            exp_cs_n_o <= 1'b0;
            exp_sdo_o  <= start_word[WIDTH-1];
            tx_sr      <= start_word << 1;
            bit_cnt    <= '0;
            poll_pend  <= 1'b0;
            idle_cnt   <= '0;
          end else begin
            if (idle_cnt != IDLE_TERM) idle_cnt <= idle_cnt + IW'(1);
            if (idle_cnt == POLL_SET)  poll_pend <= 1'b1;
          end
        end
        SHIFT: begin
          if (tick) begin
            bit_cnt <= bit_num;
            if (bit_num[0]) begin
              exp_sclk_o <= 1'b1;
              cap        <= {cap[WIDTH-2:0], exp_sdi_i};
            end else begin
              exp_sclk_o <= 1'b0;
              if (bit_num == LAST_TICK) begin
                exp_cs_n_o <= 1'b1;
                rd_data_o  <= cap;
                rd_valid_o <= 1'b1;
                state      <= IDLE;
              end else begin
                exp_sdo_o <= tx_sr[WIDTH-1];
                tx_sr     <= tx_sr << 1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_expander_gpio_sched.sv
// Directed bench for expander_gpio_sched with WIDTH=8, SCALER=1, POLL_CYCLES=100.
module tb_expander_gpio_sched;
  localparam int W = 8;

  logic         i_clk = 1'b0;
  logic         nreset_i = 1'b0;
  logic         wr_valid_i = 1'b0;
  logic         wr_ready_o;
  logic [W-1:0] wr_data_i = '0;
  logic [W-1:0] rd_data_o;
  logic         rd_valid_o, busy_o;
  logic         exp_cs_n_o, exp_sclk_o, exp_sdo_o, exp_sdi_i;

  int checks = 0;
  int errors = 0;

  // Expander model: presents inputs MSB-first, records sdo on every sclk rise.
  logic [W-1:0] exp_in = '0;
  logic [W-1:0] sdo_cap = '0;
  int           bit_idx = 0;

  expander_gpio_sched #(.WIDTH(W), .SCALER(1), .POLL_CYCLES(100), .RESET_OUT('0)) dut (
    .i_clk(i_clk), .nreset_i(nreset_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_data_i(wr_data_i),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .busy_o(busy_o),
    .exp_cs_n_o(exp_cs_n_o), .exp_sclk_o(exp_sclk_o), .exp_sdo_o(exp_sdo_o),
    .exp_sdi_i(exp_sdi_i)
  );

  always #5 i_clk = ~i_clk;

  assign exp_sdi_i = (bit_idx < W) ? exp_in[W-1-bit_idx] : 1'b0;

  always @(posedge exp_sclk_o or negedge exp_cs_n_o) begin
    if (!exp_cs_n_o && exp_sclk_o) begin
      sdo_cap = {sdo_cap[W-2:0], exp_sdo_o};
      bit_idx = bit_idx + 1;
    end else if (!exp_cs_n_o) begin
      sdo_cap = '0;
      bit_idx = 0;
    end
  end

  task automatic count_while(input logic lvl, input int budget, output int n);
    n = 0;
    while (exp_cs_n_o === lvl && n < budget) begin
      n++;
      @(negedge i_clk);
    end
  endtask

  task automatic test_reset();
    exp_in = 8'hA5;
    repeat (3) @(negedge i_clk);
    checks++;
    if ({exp_cs_n_o, exp_sclk_o, exp_sdo_o, rd_valid_o, busy_o, wr_ready_o} !== 6'b100001) begin
      errors++;
      $display("FAIL reset_pins got cs/sclk/sdo/rv/busy/rdy=%b want 100001",
               {exp_cs_n_o, exp_sclk_o, exp_sdo_o, rd_valid_o, busy_o, wr_ready_o});
    end
    checks++;
    if (rd_data_o !== 8'h00) begin
      errors++; $display("FAIL reset_rd_data got %h want 00", rd_data_o);
    end
  endtask

  task automatic test_poll_after_reset();
    int n;
    nreset_i = 1'b1;
    @(negedge i_clk);
    checks++;
    if (exp_cs_n_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++; $display("FAIL post_reset_start got cs_n=%b busy=%b want 0 1", exp_cs_n_o, busy_o);
    end
    count_while(1'b0, 200, n);
    checks++;
    if (n != 32) begin errors++; $display("FAIL post_reset_low_len got %0d want 32", n); end
    checks++;
    if (sdo_cap !== 8'h00) begin errors++; $display("FAIL post_reset_sdo got %h want 00", sdo_cap); end
    checks++;
    if (rd_valid_o !== 1'b1 || rd_data_o !== 8'hA5) begin
      errors++; $display("FAIL post_reset_rd got rv=%b data=%h want 1 a5", rd_valid_o, rd_data_o);
    end
    @(negedge i_clk);
    checks++;
    if (rd_valid_o !== 1'b0) begin errors++; $display("FAIL rd_valid_pulse got %b want 0", rd_valid_o); end
  endtask

  task automatic test_write();
    int n;
    exp_in = 8'h5A;
    repeat (3) @(negedge i_clk);
    checks++;
    if (wr_ready_o !== 1'b1) begin errors++; $display("FAIL idle_ready got %b want 1", wr_ready_o); end
    wr_valid_i = 1'b1; wr_data_i = 8'h3C;
    @(negedge i_clk);
    wr_valid_i = 1'b0;
    checks++;
    if (exp_cs_n_o !== 1'b0) begin errors++; $display("FAIL write_start got cs_n=%b want 0", exp_cs_n_o); end
    n = 0;
    while (wr_ready_o === 1'b0 && n < 200) begin n++; @(negedge i_clk); end
    checks++;
    if (n != 32) begin errors++; $display("FAIL write_ready_low got %0d want 32", n); end
    checks++;
    if (sdo_cap !== 8'h3C) begin errors++; $display("FAIL write_sdo got %h want 3c", sdo_cap); end
    checks++;
    if (rd_valid_o !== 1'b1 || rd_data_o !== 8'h5A) begin
      errors++; $display("FAIL write_rd got rv=%b data=%h want 1 5a", rd_valid_o, rd_data_o);
    end
  endtask

  task automatic test_hold_during_poll();
    int n, bad;
    count_while(1'b1, 300, n);
    checks++;
    if (n != 100) begin errors++; $display("FAIL poll_gap_after_write got %0d want 100", n); end
    wr_valid_i = 1'b1; wr_data_i = 8'h81;
    bad = 0; n = 0;
    while (exp_cs_n_o === 1'b0 && n < 200) begin
      if (wr_ready_o !== 1'b0) bad++;
      n++;
      @(negedge i_clk);
    end
    checks++;
    if (bad != 0 || n != 32) begin
      errors++; $display("FAIL stall_during_poll got ready_high=%0d len=%0d want 0 32", bad, n);
    end
    checks++;
    if (sdo_cap !== 8'h3C) begin errors++; $display("FAIL poll_resend got %h want 3c", sdo_cap); end
    count_while(1'b1, 10, n);
    wr_valid_i = 1'b0;
    checks++;
    if (n != 1) begin errors++; $display("FAIL held_write_gap got %0d want 1", n); end
    count_while(1'b0, 200, n);
    checks++;
    if (n != 32 || sdo_cap !== 8'h81) begin
      errors++; $display("FAIL held_write_shift got len=%0d sdo=%h want 32 81", n, sdo_cap);
    end
  endtask

  task automatic test_idle_collision();
    int n;
    repeat (99) @(negedge i_clk);
    checks++;
    if (exp_cs_n_o !== 1'b1) begin errors++; $display("FAIL collision_idle got cs_n=%b want 1", exp_cs_n_o); end
    wr_valid_i = 1'b1; wr_data_i = 8'hC3;
    @(negedge i_clk);
    wr_valid_i = 1'b0;
    checks++;
    if (exp_cs_n_o !== 1'b0) begin errors++; $display("FAIL collision_start got cs_n=%b want 0", exp_cs_n_o); end
    count_while(1'b0, 200, n);
    checks++;
    if (n != 32 || sdo_cap !== 8'hC3) begin
      errors++; $display("FAIL collision_shift got len=%0d sdo=%h want 32 c3", n, sdo_cap);
    end
    count_while(1'b1, 300, n);
    checks++;
    if (n != 100) begin errors++; $display("FAIL collision_next_poll got %0d want 100", n); end
  endtask

  task automatic test_poll_period();
    int n;
    count_while(1'b0, 200, n);
    checks++;
    if (n != 32 || sdo_cap !== 8'hC3) begin
      errors++; $display("FAIL period_poll got len=%0d sdo=%h want 32 c3", n, sdo_cap);
    end
    count_while(1'b1, 300, n);
    checks++;
    if (n != 100) begin errors++; $display("FAIL period_gap got %0d want 100", n); end
  endtask

  task automatic test_reset_mid();
    int n;
    exp_in = 8'h96;
    repeat (9) @(negedge i_clk);
    #2 nreset_i = 1'b0;
    #1;
    checks++;
    if ({exp_cs_n_o, exp_sclk_o, busy_o, rd_valid_o} !== 4'b1000) begin
      errors++; $display("FAIL mid_reset_pins got cs/sclk/busy/rv=%b want 1000",
                         {exp_cs_n_o, exp_sclk_o, busy_o, rd_valid_o});
    end
    @(negedge i_clk);
    checks++;
    if (rd_valid_o !== 1'b0 || rd_data_o !== 8'h00) begin
      errors++; $display("FAIL mid_reset_rd got rv=%b data=%h want 0 00", rd_valid_o, rd_data_o);
    end
    nreset_i = 1'b1;
    @(negedge i_clk);
    checks++;
    if (exp_cs_n_o !== 1'b0) begin errors++; $display("FAIL mid_reset_repoll got cs_n=%b want 0", exp_cs_n_o); end
    count_while(1'b0, 200, n);
    checks++;
    if (n != 32 || sdo_cap !== 8'h00) begin
      errors++; $display("FAIL mid_reset_shift got len=%0d sdo=%h want 32 00", n, sdo_cap);
    end
    checks++;
    if (rd_valid_o !== 1'b1 || rd_data_o !== 8'h96) begin
      errors++; $display("FAIL mid_reset_rd_after got rv=%b data=%h want 1 96", rd_valid_o, rd_data_o);
    end
  endtask

  initial begin
    test_reset();
    test_poll_after_reset();
    test_write();
    test_hold_during_poll();
    test_idle_collision();
    test_poll_period();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
